// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// holds the IF/ID register, with stall hold, flush redirect and a halt instruction.
module stage_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd1,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        Clock_in,
    input  logic        Reset_in,
    input  logic        Stall_in,
    input  logic        Flush_in,
    input  logic [31:0] Branch_target_in,
    output logic [31:0] MEM_INS_ADDR,
    input  logic [31:0] MEM_INS_DATA,
    output logic [31:0] MEM_INS_OUT,
    output logic [31:0] PC_NEXT_INS_OUT,
    output logic        IF_VALID_OUT,
    output logic        HALTED_OUT,
    output logic [31:0] FETCH_COUNT_OUT
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_ins, w_ins;
    logic [31:0] r_pc_next, w_pc_next;
    logic        r_valid, w_valid;
    logic [31:0] r_count, w_count;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + PC_STEP;

    always_comb begin
        w_state   = r_state;
        w_pc      = r_pc;
        w_ins     = r_ins;
        w_pc_next = r_pc_next;
        w_valid   = r_valid;
        w_count   = r_count;
        case (r_state)
            StBoot: w_state = StRun;
            StRun: begin
                // Flush outranks stall; PC_NEXT and count keep their last real values.
                if (Flush_in) begin
                    w_pc    = Branch_target_in;
                    w_ins   = NOP_WORD;
                    w_valid = 1'b0;
                end else if (!Stall_in) begin
                    w_ins     = MEM_INS_DATA;
                    w_pc_next = w_pc_inc;
                    w_valid   = 1'b1;
                    w_count   = r_count + 32'd1;
                    if (MEM_INS_DATA == HALT_WORD) begin
                        w_state = StHalt;
                    end else begin
                        w_pc = w_pc_inc;
                    end
                end
            end
            StHalt: begin
                // A flush here cancels a halt that was fetched down a mispredicted path.
                if (Flush_in) begin
                    w_pc    = Branch_target_in;
                    w_ins   = NOP_WORD;
                    w_valid = 1'b0;
                    w_state = StRun;
                end else if (!Stall_in) begin
                    w_ins   = NOP_WORD;
                    w_valid = 1'b0;
                end
            end
            default: w_state = StBoot;
        endcase
    end

    always_ff @(posedge Clock_in or posedge Reset_in) begin
        if (Reset_in) begin
            r_state   <= StBoot;
            r_pc      <= RESET_PC;
            r_ins     <= NOP_WORD;
            r_pc_next <= 32'd0;
            r_valid   <= 1'b0;
            r_count   <= 32'd0;
        end else begin
            r_state   <= w_state;
            r_pc      <= w_pc;
            r_ins     <= w_ins;
            r_pc_next <= w_pc_next;
            r_valid   <= w_valid;
            r_count   <= w_count;
        end
    end

    assign MEM_INS_ADDR    = r_pc;
    assign MEM_INS_OUT     = r_ins;
    assign PC_NEXT_INS_OUT = r_pc_next;
    assign IF_VALID_OUT    = r_valid;
    assign HALTED_OUT      = (r_state == StHalt);
    assign FETCH_COUNT_OUT = r_count;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: table of {inputs, expected IF/ID state} applied per edge through a
// scoreboard queue, plus hand sequences for reset, BOOT and asynchronous mid-cycle reset.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] ins_out;
    logic [31:0] pcn_out;
    logic        valid_out;
    logic        halted_out;
    logic [31:0] count_out;
    logic        halt3;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pcn;
        logic        valid;
        logic        halted;
        logic [31:0] addr;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        halt3;
        logic [31:0] target;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Memory model: mem[i] = 0x1000_0000 + i, optionally with the halt word at address 3.
    always_comb begin
        mem_data = 32'h1000_0000 + mem_addr;
        if (halt3 && mem_addr == 32'd3) mem_data = 32'hFFFF_FFFF;
    end

    stage_if dut (
        .Clock_in        (clk),
        .Reset_in        (rst),
        .Stall_in        (stall),
        .Flush_in        (flush),
        .Branch_target_in(target),
        .MEM_INS_ADDR    (mem_addr),
        .MEM_INS_DATA    (mem_data),
        .MEM_INS_OUT     (ins_out),
        .PC_NEXT_INS_OUT (pcn_out),
        .IF_VALID_OUT    (valid_out),
        .HALTED_OUT      (halted_out),
        .FETCH_COUNT_OUT (count_out)
    );

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pcn,
                                input logic valid, input logic halted,
                                input logic [31:0] addr, input logic [31:0] cnt);
        exp_t e;
        e.ins = ins; e.pcn = pcn; e.valid = valid; e.halted = halted;
        e.addr = addr; e.cnt = cnt;
        return e;
    endfunction

    task automatic add(input logic s, input logic f, input logic h, input logic [31:0] t,
                       input exp_t e);
        vec_t v;
        v.stall = s; v.flush = f; v.halt3 = h; v.target = t; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=none required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".ins"},    ins_out,              e.ins);
            chk({tag, ".pcn"},    pcn_out,              e.pcn);
            chk({tag, ".valid"},  {31'd0, valid_out},   {31'd0, e.valid});
            chk({tag, ".halted"}, {31'd0, halted_out},  {31'd0, e.halted});
            chk({tag, ".addr"},   mem_addr,             e.addr);
            chk({tag, ".count"},  count_out,            e.cnt);
        end
    endtask

    initial begin
        // Sequential fetch from 0 up to PC=5.
        add(0, 0, 0, 0, mk(32'h1000_0000, 1, 1, 0, 1, 1));
        add(0, 0, 0, 0, mk(32'h1000_0001, 2, 1, 0, 2, 2));
        add(0, 0, 0, 0, mk(32'h1000_0002, 3, 1, 0, 3, 3));
        add(0, 0, 0, 0, mk(32'h1000_0003, 4, 1, 0, 4, 4));
        add(0, 0, 0, 0, mk(32'h1000_0004, 5, 1, 0, 5, 5));
        // Three stall cycles at PC=5, then release.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, mk(32'h1000_0004, 5, 1, 0, 5, 5));
        add(0, 0, 0, 0, mk(32'h1000_0005, 6, 1, 0, 6, 6));
        // Flush with simultaneous stall.
        add(1, 1, 0, 32'h40, mk(32'h0, 6, 0, 0, 32'h40, 6));
        add(0, 0, 0, 0, mk(32'h1000_0040, 32'h41, 1, 0, 32'h41, 7));
        // PC wrap.
        add(0, 1, 0, 32'hFFFF_FFFF, mk(32'h0, 32'h41, 0, 0, 32'hFFFF_FFFF, 7));
        add(0, 0, 0, 0, mk(32'h0FFF_FFFF, 0, 1, 0, 0, 8));
        add(0, 0, 0, 0, mk(32'h1000_0000, 1, 1, 0, 1, 9));
        // Halt at address 3: delivered once, held by stall, then bubbles; flush resumes.
        add(0, 1, 1, 3, mk(32'h0, 1, 0, 0, 3, 9));
        add(0, 0, 1, 0, mk(32'hFFFF_FFFF, 4, 1, 1, 3, 10));
        add(1, 0, 1, 0, mk(32'hFFFF_FFFF, 4, 1, 1, 3, 10));
        add(0, 0, 1, 0, mk(32'h0, 4, 0, 1, 3, 10));
        add(0, 0, 1, 0, mk(32'h0, 4, 0, 1, 3, 10));
        add(0, 1, 1, 32'h10, mk(32'h0, 4, 0, 0, 32'h10, 10));
        add(0, 0, 1, 0, mk(32'h1000_0010, 32'h11, 1, 0, 32'h11, 11));
        // Flush on the same edge the halt word is presented: no halt.
        add(0, 1, 1, 3, mk(32'h0, 32'h11, 0, 0, 3, 11));
        add(0, 1, 1, 32'h20, mk(32'h0, 32'h11, 0, 0, 32'h20, 11));
        add(0, 0, 1, 0, mk(32'h1000_0020, 32'h21, 1, 0, 32'h21, 12));
        add(0, 0, 1, 0, mk(32'h1000_0021, 32'h22, 1, 0, 32'h22, 13));

        rst = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0; halt3 = 1'b0;
        #2;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        compare("reset");
        #10 rst = 1'b0;

        // BOOT edge: nothing moves, even with a flush request.
        flush = 1'b1; target = 32'h99;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        compare("boot");

        foreach (vecs[i]) begin
            stall = vecs[i].stall; flush = vecs[i].flush;
            target = vecs[i].target; halt3 = vecs[i].halt3;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk); #1;
            compare($sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges.
        stall = 1'b0; flush = 1'b0; halt3 = 1'b0;
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        compare("async_rst");
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        compare("rst_held");
        #2 rst = 1'b0;
        flush = 1'b1; target = 32'h99;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        compare("boot2");
        flush = 1'b0;
        exp_q.push_back(mk(32'h1000_0000, 1, 1, 0, 1, 1));
        @(posedge clk); #1;
        compare("after_boot2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and drives the instruction-memory address. It also holds the IF/ID pipeline register, which supplies the decode stage with its instruction word and next-PC value. It handles stall (hold), flush/branch redirect (bubble insertion) and a halt instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 32'd1, PC increment per fetched instruction (word-addressed memory)
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble
HALT_WORD, 32'hFFFF_FFFF, instruction word that halts fetch

Ports:
Clock_in  in  1  system clock, rising edge
Reset_in  in  1  asynchronous, active-high reset
Stall_in  in  1  hold PC and IF/ID register (hazard from decode)
Flush_in  in  1  branch taken: redirect PC, squash IF/ID
Branch_target_in  in  32  new PC when Flush_in=1
MEM_INS_ADDR  out  32  instruction-memory address (= PC, combinational)
MEM_INS_DATA  in  32  instruction-memory read data (combinational read of MEM_INS_ADDR)
MEM_INS_OUT  out  32  IF/ID instruction register, feeds decode
PC_NEXT_INS_OUT  out  32  IF/ID next-PC register (fetch PC + PC_STEP), feeds decode
IF_VALID_OUT  out  1  IF/ID holds a real instruction (0 = bubble)
HALTED_OUT  out  1  fetch is in HALT state
FETCH_COUNT_OUT  out  32  number of instructions delivered to IF/ID

Behaviour:
- Reset (async, any time, including mid-operation):
  - PC=RESET_PC; MEM_INS_OUT=NOP_WORD; PC_NEXT_INS_OUT=0.
  - IF_VALID_OUT=0, HALTED_OUT=0, FETCH_COUNT_OUT=0, state=BOOT.
- MEM_INS_ADDR = PC at all times. There is no registered address.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset release, then goes to RUN. PC and IF/ID hold their reset values; inputs are ignored.
  - RUN: per rising edge, in priority order:
    1. Flush_in=1: PC<=Branch_target_in; MEM_INS_OUT<=NOP_WORD; IF_VALID_OUT<=0; PC_NEXT_INS_OUT holds; count holds. Flush overrides a simultaneous Stall_in.
    2. Stall_in=1: PC, IF/ID, valid and count all hold.
    3. Otherwise: MEM_INS_OUT<=MEM_INS_DATA; PC_NEXT_INS_OUT<=PC+PC_STEP; IF_VALID_OUT<=1; FETCH_COUNT_OUT<=count+1. If MEM_INS_DATA==HALT_WORD: PC holds and state<=HALT. Else PC<=PC+PC_STEP.
  - HALT: HALTED_OUT=1, set on the same edge that latches the halt word. The halt word itself is delivered to decode once with valid=1.
    - Next edge without Flush (Stall_in=0): IF/ID<=NOP_WORD, valid<=0.
    - Next edge with Stall_in=1: IF/ID holds the halt word.
    - Flush_in=1 in HALT: PC<=Branch_target_in, IF/ID<=NOP, valid<=0, state<=RUN, HALTED_OUT<=0. This cancels a halt fetched on a wrong path.
- Arithmetic: PC+PC_STEP and the count wrap modulo 2^32 with no flag (0xFFFF_FFFF+1 -> 0).
- A flush on the same edge as a would-be halt fetch: the flush wins, no halt.
- All outputs except MEM_INS_ADDR are registered. Fetch-to-decode latency is 1 cycle.

Test Plan:
1. Reset, RESET_PC=0, memory[i]=0x1000_0000+i, no stall/flush.
   - Cycle after BOOT: MEM_INS_OUT=0x1000_0000, PC_NEXT_INS_OUT=1, valid=1.
   - Next cycles follow sequentially; FETCH_COUNT_OUT increments by 1 per cycle.
2. Stall_in=1 for 3 cycles at PC=5.
   - MEM_INS_ADDR stays 5; MEM_INS_OUT/PC_NEXT_INS_OUT/count frozen.
   - After release, mem[5] is delivered with PC_NEXT=6.
3. Flush_in=1 with Branch_target_in=0x40 while Stall_in=1.
   - Next cycle: PC=0x40, MEM_INS_OUT=NOP_WORD, valid=0.
   - Following cycle: mem[0x40] delivered, PC_NEXT=0x41.
4. mem[3]=HALT_WORD.
   - HALT_WORD delivered once with valid=1; HALTED_OUT=1; MEM_INS_ADDR stays 3.
   - Following cycles: NOP, valid=0.
   - Flush_in=1 with target 0x10: HALTED_OUT=0, fetch resumes at 0x10.
5. Branch_target_in=0xFFFF_FFFF, then run.
   - PC_NEXT_INS_OUT=0 and next MEM_INS_ADDR=0, demonstrating wrap.
6. Assert Reset_in mid-stream, between clock edges.
   - All outputs return to reset values immediately, without waiting for a clock edge.
   - BOOT cycle is observed after release.
